associative_cache_4way: RTL and testbench

4-way set-associative, write-back, write-allocate data cache with one 32-bit word per line. It sits between the processor load/store path and a slower main-memory model. Memory completion is signalled by MemReadFinish/MemWriteFinish. Each request is one Start pulse; completion is a one-cycle ReadReady or WriteReady pulse.

---
 rtl/associative_cache_4way.sv | 223 ++++++++++++++++++++++
 tb/tb_associative_cache_4way.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/associative_cache_4way.sv
// 4-way set-associative, write-back, write-allocate cache, one 32-bit word per line.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for Start; latches the request when it arrives
// COMPARE   | tag lookup; a hit completes, a miss picks a victim
// WRITEBACK | dirty victim being written to memory (MemWrite held)
// ALLOCATE  | refill from memory (MemRead held), then back to COMPARE
module associative_cache_4way #(
    parameter int NUM_SETS = 16,
    parameter int WAYS     = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Start,
    input  logic        WriteEnable,
    input  logic [31:0] RWAddr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        WriteReady,
    output logic        ReadReady,
    input  logic        MemReadFinish,
    input  logic        MemWriteFinish,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWriteData,
    input  logic [31:0] MemReadData
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

    state_t r_state, w_state_nxt;

    logic             r_valid [WAYS][NUM_SETS];
    logic             r_dirty [WAYS][NUM_SETS];
    logic [1:0]       r_age   [WAYS][NUM_SETS];
    logic [TAG_W-1:0] r_tag   [WAYS][NUM_SETS];
    logic [31:0]      r_data  [WAYS][NUM_SETS];

    logic [31:2] r_addr;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [1:0]  r_victim;

    logic [31:0] r_read_data;
    logic        r_read_ready;
    logic        r_write_ready;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [WAYS-1:0]  w_hit_vec;
    logic             w_hit;
    logic [1:0]       w_hit_way;
    logic [1:0]       w_hit_age;
    logic [1:0]       w_victim;
    logic             w_victim_found;
    logic             w_victim_dirty;
    logic             w_latch;
    logic             w_do_hit;
    logic             w_do_miss;
    logic             w_wb_done;
    logic             w_fill;
    logic             w_unused_addr;

    assign w_idx         = r_addr[2 +: IDX_W];
    assign w_tag         = r_addr[31 -: TAG_W];
    assign w_unused_addr = ^RWAddr[1:0];

    assign ReadData     = r_read_data;
    assign ReadReady    = r_read_ready;
    assign WriteReady   = r_write_ready;
    assign MemRead      = r_mem_read;
    assign MemWrite     = r_mem_write;
    assign MemAddr      = r_mem_addr;
    assign MemWriteData = r_mem_wdata;

    // Tag compare across the four ways of the addressed set.
    always_comb begin
        w_hit_way = 2'd0;
        for (int w = 0; w < WAYS; w++) begin
            w_hit_vec[w] = r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag);
            if (w_hit_vec[w]) w_hit_way = 2'(w);
        end
        w_hit     = |w_hit_vec;
        w_hit_age = r_age[w_hit_way][w_idx];
    end

    // Victim: lowest-index invalid way, else the oldest (age 3) way.
    always_comb begin
        w_victim       = 2'd0;
        w_victim_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!r_valid[w][w_idx] && !w_victim_found) begin
                w_victim       = 2'(w);
                w_victim_found = 1'b1;
            end
        end
        if (!w_victim_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (r_age[w][w_idx] == 2'd3) w_victim = 2'(w);
            end
        end
        w_victim_dirty = r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx];
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (Start) w_state_nxt = COMPARE;
            COMPARE: begin
                if (w_hit)               w_state_nxt = IDLE;
                else if (w_victim_dirty) w_state_nxt = WRITEBACK;
                else                     w_state_nxt = ALLOCATE;
            end
            WRITEBACK: if (MemWriteFinish) w_state_nxt = ALLOCATE;
            ALLOCATE:  if (MemReadFinish)  w_state_nxt = COMPARE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // Per-state action strobes that drive the datapath.
    always_comb begin
        w_latch   = (r_state == IDLE)      && Start;
        w_do_hit  = (r_state == COMPARE)   && w_hit;
        w_do_miss = (r_state == COMPARE)   && !w_hit;
        w_wb_done = (r_state == WRITEBACK) && MemWriteFinish;
        w_fill    = (r_state == ALLOCATE)  && MemReadFinish;
    end

    // Line status, LRU ages, request latch and registered outputs.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    r_valid[w][s] <= 1'b0;
                    r_dirty[w][s] <= 1'b0;
                    r_age[w][s]   <= 2'(w);
                end
            end
            r_addr        <= '0;
            r_we          <= 1'b0;
            r_wdata       <= '0;
            r_victim      <= 2'd0;
            r_read_data   <= '0;
            r_read_ready  <= 1'b0;
            r_write_ready <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
        end else begin
            r_read_ready  <= 1'b0;
            r_write_ready <= 1'b0;
            if (w_latch) begin
                r_addr  <= RWAddr[31:2];
                r_we    <= WriteEnable;
                r_wdata <= WriteData;
            end
            if (w_do_hit) begin
                if (r_we) begin
                    r_dirty[w_hit_way][w_idx] <= 1'b1;
                    r_write_ready             <= 1'b1;
                end else begin
                    r_read_data  <= r_data[w_hit_way][w_idx];
                    r_read_ready <= 1'b1;
                end
                for (int w = 0; w < WAYS; w++) begin
                    if (2'(w) == w_hit_way)           r_age[w][w_idx] <= 2'd0;
                    else if (r_age[w][w_idx] < w_hit_age) r_age[w][w_idx] <= r_age[w][w_idx] + 2'd1;
                end
            end
            if (w_do_miss) begin
                r_victim <= w_victim;
                if (w_victim_dirty) begin
                    r_mem_write <= 1'b1;
                    r_mem_addr  <= {r_tag[w_victim][w_idx], w_idx, 2'b00};
                    r_mem_wdata <= r_data[w_victim][w_idx];
                end else begin
                    r_mem_read <= 1'b1;
                    r_mem_addr <= {r_addr, 2'b00};
                end
            end
            if (w_wb_done) begin
                r_mem_write              <= 1'b0;
                r_dirty[r_victim][w_idx] <= 1'b0;
                r_mem_read               <= 1'b1;
                r_mem_addr               <= {r_addr, 2'b00};
            end
            if (w_fill) begin
                r_valid[r_victim][w_idx] <= 1'b1;
                r_dirty[r_victim][w_idx] <= 1'b0;
                r_mem_read               <= 1'b0;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits guard their contents.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            if (w_do_hit && r_we) r_data[w_hit_way][w_idx] <= r_wdata;
            if (w_fill) begin
                r_data[r_victim][w_idx] <= MemReadData;
                r_tag[r_victim][w_idx]  <= w_tag;
            end
        end
    end

endmodule

// File: tb/tb_associative_cache_4way.sv
// Directed bench for associative_cache_4way with a hand-driven memory model.
module tb_associative_cache_4way;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic        WriteEnable;
    logic [31:0] RWAddr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        WriteReady;
    logic        ReadReady;
    logic        MemReadFinish;
    logic        MemWriteFinish;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemAddr;
    logic [31:0] MemWriteData;
    logic [31:0] MemReadData;

    int n_tests = 0;
    int n_fail  = 0;

    associative_cache_4way dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .WriteEnable(WriteEnable),
        .RWAddr(RWAddr), .WriteData(WriteData), .ReadData(ReadData),
        .WriteReady(WriteReady), .ReadReady(ReadReady),
        .MemReadFinish(MemReadFinish), .MemWriteFinish(MemWriteFinish),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemAddr(MemAddr),
        .MemWriteData(MemWriteData), .MemReadData(MemReadData)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic we, input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        Start = 1'b1; WriteEnable = we; RWAddr = a; WriteData = d;
        @(negedge CLK);
        Start = 1'b0;
    endtask

    task automatic wait_memread(input string tag, input logic [31:0] exp_addr);
        int k = 0;
        while (!MemRead && k < 30) begin @(negedge CLK); k++; end
        check({tag, " mem_read"}, MemRead, 1);
        check({tag, " mem_addr"}, MemAddr, exp_addr);
        check({tag, " no_mem_write"}, MemWrite, 0);
    endtask

    task automatic finish_memread(input string tag, input logic [31:0] data);
        repeat (2) @(negedge CLK);
        check({tag, " mem_read_held"}, MemRead, 1);
        MemReadData = data; MemReadFinish = 1'b1;
        @(negedge CLK);
        MemReadFinish = 1'b0; MemReadData = 32'h0;
        check({tag, " mem_read_drop"}, MemRead, 0);
    endtask

    task automatic mem_writeback(input string tag, input logic [31:0] exp_addr, input logic [31:0] exp_data);
        int k = 0;
        while (!MemWrite && k < 30) begin @(negedge CLK); k++; end
        check({tag, " mem_write"}, MemWrite, 1);
        check({tag, " wb_addr"}, MemAddr, exp_addr);
        check({tag, " wb_data"}, MemWriteData, exp_data);
        check({tag, " wb_no_read"}, MemRead, 0);
        repeat (2) @(negedge CLK);
        MemWriteFinish = 1'b1;
        @(negedge CLK);
        MemWriteFinish = 1'b0;
        check({tag, " wb_drop"}, MemWrite, 0);
    endtask

    task automatic wait_ready(input string tag, input logic is_wr, input logic [31:0] exp);
        int k = 0;
        while (!(ReadReady || WriteReady) && k < 30) begin @(negedge CLK); k++; end
        check({tag, " read_ready"}, ReadReady, !is_wr);
        check({tag, " write_ready"}, WriteReady, is_wr);
        if (!is_wr) check({tag, " read_data"}, ReadData, exp);
        @(negedge CLK);
        check({tag, " ready_pulse_end"}, ReadReady | WriteReady, 0);
    endtask

    initial begin
        int pulses;
        Reset = 1'b1; Start = 1'b0; WriteEnable = 1'b0; RWAddr = '0; WriteData = '0;
        MemReadFinish = 1'b0; MemWriteFinish = 1'b0; MemReadData = '0;
        repeat (3) @(negedge CLK);
        Reset = 1'b0;
        check("rst ReadData", ReadData, 0);
        check("rst ReadReady", ReadReady, 0);
        check("rst WriteReady", WriteReady, 0);
        check("rst MemRead", MemRead, 0);
        check("rst MemWrite", MemWrite, 0);
        check("rst MemAddr", MemAddr, 0);
        check("rst MemWriteData", MemWriteData, 0);

        // cold read miss at 0x0
        start_req(1'b0, 32'h0, 32'h0);
        wait_memread("rd0", 32'h0);
        finish_memread("rd0", 32'hA5A5A5A5);
        wait_ready("rd0", 1'b0, 32'hA5A5A5A5);

        // write miss at 0x4, store merged after refill
        start_req(1'b1, 32'h4, 32'h12345678);
        wait_memread("wr4", 32'h4);
        finish_memread("wr4", 32'hDEADBEEF);
        wait_ready("wr4", 1'b1, 32'h0);

        // read hit at 0x4, exact two-cycle latency
        start_req(1'b0, 32'h4, 32'h0);
        check("hit4 early_ready", ReadReady, 0);
        check("hit4 early_mem_read", MemRead, 0);
        @(negedge CLK);
        check("hit4 read_ready", ReadReady, 1);
        check("hit4 read_data", ReadData, 32'h12345678);
        check("hit4 no_mem_read", MemRead, 0);
        @(negedge CLK);
        check("hit4 pulse_end", ReadReady, 0);

        // fill the remaining ways of set 1
        start_req(1'b0, 32'h44, 32'h0);
        wait_memread("rd44", 32'h44);
        finish_memread("rd44", 32'h44440000);
        wait_ready("rd44", 1'b0, 32'h44440000);
        start_req(1'b0, 32'h84, 32'h0);
        wait_memread("rd84", 32'h84);
        finish_memread("rd84", 32'h84840000);
        wait_ready("rd84", 1'b0, 32'h84840000);
        start_req(1'b0, 32'hC4, 32'h0);
        wait_memread("rdC4", 32'hC4);
        finish_memread("rdC4", 32'hC4C40000);
        wait_ready("rdC4", 1'b0, 32'hC4C40000);

        // 0x104 evicts LRU line 0x04, which is dirty
        start_req(1'b0, 32'h104, 32'h0);
        mem_writeback("ev104", 32'h4, 32'h12345678);
        wait_memread("ev104", 32'h104);
        finish_memread("ev104", 32'h01040104);
        wait_ready("ev104", 1'b0, 32'h01040104);

        // Start held high during COMPARE/ALLOCATE must be ignored
        start_req(1'b0, 32'h200, 32'h0);
        Start = 1'b1; WriteEnable = 1'b1; RWAddr = 32'h300; WriteData = 32'hFFFF0000;
        @(negedge CLK);
        @(negedge CLK);
        Start = 1'b0;
        wait_memread("busy", 32'h200);
        finish_memread("busy", 32'h20020020);
        wait_ready("busy", 1'b0, 32'h20020020);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (ReadReady || WriteReady || MemRead || MemWrite) pulses++;
        end
        check("busy extra_activity", pulses, 0);

        // reset during ALLOCATE aborts the refill and invalidates lines
        start_req(1'b0, 32'h8, 32'h0);
        wait_memread("rst_alloc", 32'h8);
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        check("rst_alloc mem_read_drop", MemRead, 0);
        check("rst_alloc read_data", ReadData, 0);
        start_req(1'b0, 32'h104, 32'h0);
        wait_memread("post_rst104", 32'h104);
        finish_memread("post_rst104", 32'h0BADF00D);
        wait_ready("post_rst104", 1'b0, 32'h0BADF00D);
        start_req(1'b0, 32'h4, 32'h0);
        wait_memread("post_rst4", 32'h4);
        finish_memread("post_rst4", 32'h44444444);
        wait_ready("post_rst4", 1'b0, 32'h44444444);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
